// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pool_pkg
// Description : Shared types, constants and helpers for the pool_stream unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pool_pkg;

  // Reduction applied to each window.
  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  // Tile sequencing state: IDLE waits for a tile's first row, ACCUM is mid-tile.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } pool_state_e;

  // Headroom above the element width: a 4x4 window sums 16 elements (+4 bits).
  localparam int ACC_GUARD = 4;
  // Accumulator width for the default 8-bit element; instances derive their
  // own width as DWIDTH + ACC_GUARD.
  localparam int ACC_WIDTH = 8 + ACC_GUARD;

  // log2 of the window size; anything other than 2 or 4 behaves as a 1x1 window.
  function automatic logic [1:0] win_log2(input int unsigned size);
    case (size)
      2:       win_log2 = 2'd1;
      4:       win_log2 = 2'd2;
      default: win_log2 = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_lane_acc.sv
`default_nettype none
// ============================================================================
// Module      : pool_lane_acc
// Description : One output lane of pool_stream: horizontal reduce of up to four
//               masked input elements, vertical accumulate across the rows of a
//               window, and finalise to an average or a maximum.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_lane_acc
  import pool_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int ACC_W  = DWIDTH + ACC_GUARD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   accept,
  input  logic                   first,
  input  pool_mode_e             mode,
  input  logic [1:0]             wlog2,
  input  logic [3:0][DWIDTH-1:0] elems,
  input  logic [3:0]             mask,
  output logic [DWIDTH-1:0]      result,
  output logic                   valid
);

  logic [ACC_W-1:0] acc_q, acc_d, acc_next;
  logic [ACC_W-1:0] row_sum, row_max;
  logic             vld_q, vld_d, vld_next;

  // Horizontal reduce: masked elements count as zero for both sum and max.
  always_comb begin
    logic [ACC_W-1:0] e;
    row_sum = '0;
    row_max = '0;
    for (int j = 0; j < 4; j++) begin
      e = mask[j] ? ACC_W'(elems[j]) : '0;
      row_sum = row_sum + e;
      if (e > row_max) row_max = e;
    end
  end

  // Vertical combine: the first row of a window overwrites, later rows merge.
  always_comb begin
    if (mode == POOL_MAX) begin
      acc_next = (first || row_max > acc_q) ? row_max : acc_q;
    end else begin
      acc_next = first ? row_sum : acc_q + row_sum;
    end
    vld_next = first ? |mask : (vld_q | |mask);
  end

  // Finalise: average divides by W*W via a shift of 2*log2(W), truncating.
  always_comb begin
    if (mode == POOL_MAX) begin
      result = acc_next[DWIDTH-1:0];
    end else begin
      result = DWIDTH'(acc_next >> {wlog2, 1'b0});
    end
    valid = vld_next;
  end

  // Accumulator next-state: abort clears, accepted rows advance, gaps hold.
  always_comb begin
    acc_d = acc_q;
    vld_d = vld_q;
    if (clear) begin
      acc_d = '0;
      vld_d = 1'b0;
    end else if (accept) begin
      acc_d = acc_next;
      vld_d = vld_next;
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      vld_q <= vld_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pool_stream.sv
`default_nettype none
// ============================================================================
// Module      : pool_stream
// Description : Streaming WxW / stride-W pooling (average or max) over
//               DESIGN_SIZE-lane rows, with bypass, per-lane validity masking,
//               tile-end pulse and abort on enable_pool falling.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_stream
  import pool_pkg::*;
#(
  parameter int DWIDTH        = 8,
  parameter int DESIGN_SIZE   = 16,
  parameter int MAX_BITS_POOL = 3,
  parameter int TILE_ROWS     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable_pool,
  input  logic                          pool_mode,
  input  logic [MAX_BITS_POOL-1:0]      pool_window_size,
  input  logic                          in_data_available,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
  input  logic [DESIGN_SIZE-1:0]        validity_mask,
  output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
  output logic [DESIGN_SIZE-1:0]        out_validity_mask,
  output logic                          out_data_available,
  output logic                          done_pool
);

  localparam int ACC_W  = DWIDTH + ACC_GUARD;
  localparam int LANE_W = $clog2(DESIGN_SIZE);
  localparam int ROW_W  = $clog2(TILE_ROWS);

  pool_state_e                   state_q, state_d;
  pool_mode_e                    mode_q, mode_d, eff_mode;
  logic [1:0]                    wlog2_q, wlog2_d, eff_wlog2;
  logic [1:0]                    win_cnt_q, win_cnt_d, win_last_idx;
  logic [ROW_W-1:0]              row_cnt_q, row_cnt_d;
  logic [DESIGN_SIZE*DWIDTH-1:0] out_data_q, out_data_d, pooled;
  logic [DESIGN_SIZE-1:0]        out_mask_q, out_mask_d, lane_vld;
  logic                          out_dav_q, out_dav_d, done_q, done_d;
  logic                          accept, first, win_last, row_last;

  logic [DWIDTH-1:0]             in_lane   [DESIGN_SIZE];
  logic [3:0][DWIDTH-1:0]        win_elems [DESIGN_SIZE];
  logic [3:0]                    win_mask  [DESIGN_SIZE];
  logic [DWIDTH-1:0]             lane_res  [DESIGN_SIZE];

  // Effective config: live inputs on a tile's first row, latched values after.
  always_comb begin
    eff_mode  = (state_q == ST_IDLE) ? pool_mode_e'(pool_mode) : mode_q;
    eff_wlog2 = (state_q == ST_IDLE) ? win_log2(32'(pool_window_size)) : wlog2_q;
    case (eff_wlog2)
      2'd1:    win_last_idx = 2'd1;
      2'd2:    win_last_idx = 2'd3;
      default: win_last_idx = 2'd0;
    endcase
    accept   = enable_pool & in_data_available;
    first    = (win_cnt_q == 2'd0);
    win_last = (win_cnt_q == win_last_idx);
    row_last = (row_cnt_q == ROW_W'(TILE_ROWS - 1));
  end

  // Route input lanes kW..kW+W-1 to output lane k; out-of-range slots are empty.
  always_comb begin
    int win_size;
    int pos;
    win_size = 1 << eff_wlog2;
    for (int i = 0; i < DESIGN_SIZE; i++) begin
      in_lane[i] = inp_data[i*DWIDTH +: DWIDTH];
    end
    for (int k = 0; k < DESIGN_SIZE; k++) begin
      for (int j = 0; j < 4; j++) begin
        win_elems[k][j] = '0;
        win_mask[k][j]  = 1'b0;
        pos = k * win_size + j;
        if (j < win_size && pos < DESIGN_SIZE) begin
          win_elems[k][j] = in_lane[pos[LANE_W-1:0]];
          win_mask[k][j]  = validity_mask[pos[LANE_W-1:0]];
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < DESIGN_SIZE; k++) begin : g_lane
      pool_lane_acc #(
        .DWIDTH (DWIDTH),
        .ACC_W  (ACC_W)
      ) u_lane (
        .clk    (clk),
        .reset  (reset),
        .clear  (~enable_pool),
        .accept (accept),
        .first  (first),
        .mode   (eff_mode),
        .wlog2  (eff_wlog2),
        .elems  (win_elems[k]),
        .mask   (win_mask[k]),
        .result (lane_res[k]),
        .valid  (lane_vld[k])
      );
    end
  endgenerate

  // Pack per-lane results into an output row.
  always_comb begin
    for (int k = 0; k < DESIGN_SIZE; k++) begin
      pooled[k*DWIDTH +: DWIDTH] = lane_res[k];
    end
  end

  // Sequencing: bypass/abort when disabled, else count rows and windows.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    wlog2_d    = wlog2_q;
    win_cnt_d  = win_cnt_q;
    row_cnt_d  = row_cnt_q;
    out_data_d = out_data_q;
    out_mask_d = out_mask_q;
    out_dav_d  = 1'b0;
    done_d     = 1'b0;
    if (!enable_pool) begin
      // Also covers a row arriving on the falling edge: it is passed through.
      state_d    = ST_IDLE;
      win_cnt_d  = 2'd0;
      row_cnt_d  = '0;
      out_data_d = inp_data;
      out_mask_d = validity_mask;
      out_dav_d  = in_data_available;
    end else if (in_data_available) begin
      if (state_q == ST_IDLE) begin
        mode_d  = eff_mode;
        wlog2_d = eff_wlog2;
      end
      win_cnt_d = win_last ? 2'd0 : win_cnt_q + 2'd1;
      row_cnt_d = row_last ? '0 : row_cnt_q + 1'b1;
      // W=1 tiles still pass through ACCUM so the row count marks the tile end.
      state_d   = row_last ? ST_IDLE : ST_ACCUM;
      if (win_last) begin
        out_data_d = pooled;
        out_mask_d = lane_vld;
        out_dav_d  = 1'b1;
        done_d     = row_last;
      end
    end
  end

  // State, config latch, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= POOL_AVG;
      wlog2_q    <= 2'd0;
      win_cnt_q  <= 2'd0;
      row_cnt_q  <= '0;
      out_data_q <= '0;
      out_mask_q <= '0;
      out_dav_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wlog2_q    <= wlog2_d;
      win_cnt_q  <= win_cnt_d;
      row_cnt_q  <= row_cnt_d;
      out_data_q <= out_data_d;
      out_mask_q <= out_mask_d;
      out_dav_q  <= out_dav_d;
      done_q     <= done_d;
    end
  end

  assign out_data           = out_data_q;
  assign out_validity_mask  = out_mask_q;
  assign out_data_available = out_dav_q;
  assign done_pool          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_stream
// Description : Self-checking bench for pool_stream against a window-level
//               reference model of the pooling rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_stream;

  localparam int DW  = 8;
  localparam int DS  = 16;
  localparam int MBP = 3;
  localparam int TR  = 16;
  localparam int VW  = DS * DW;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable_pool;
  logic           pool_mode;
  logic [MBP-1:0] pool_window_size;
  logic           in_data_available;
  logic [VW-1:0]  inp_data;
  logic [DS-1:0]  validity_mask;
  logic [VW-1:0]  out_data;
  logic [DS-1:0]  out_validity_mask;
  logic           out_data_available;
  logic           done_pool;

  int             total = 0;
  int             bad   = 0;
  int             strobes;
  int             dones;
  logic [VW-1:0]  rows  [TR];
  logic [DS-1:0]  masks [TR];
  logic [VW-1:0]  first_data;
  logic [DS-1:0]  first_mask;
  logic [VW-1:0]  saved_data;
  logic [DS-1:0]  saved_mask;

  always #5 clk = ~clk;

  pool_stream #(
    .DWIDTH        (DW),
    .DESIGN_SIZE   (DS),
    .MAX_BITS_POOL (MBP),
    .TILE_ROWS     (TR)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable_pool        (enable_pool),
    .pool_mode          (pool_mode),
    .pool_window_size   (pool_window_size),
    .in_data_available  (in_data_available),
    .inp_data           (inp_data),
    .validity_mask      (validity_mask),
    .out_data           (out_data),
    .out_validity_mask  (out_validity_mask),
    .out_data_available (out_data_available),
    .done_pool          (done_pool)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: pooled result of window row-group wi, from the whole WxW block.
  task automatic model_window(input int w, input int mode, input int wi,
                              output logic [VW-1:0] d, output logic [DS-1:0] m);
    int sum, mx, v;
    bit any;
    d = '0;
    m = '0;
    for (int k = 0; k < DS / w; k++) begin
      sum = 0;
      mx  = 0;
      any = 1'b0;
      for (int r = wi * w; r < wi * w + w; r++) begin
        for (int c = k * w; c < k * w + w; c++) begin
          v = masks[r][c] ? int'(rows[r][c*DW +: DW]) : 0;
          sum += v;
          if (v > mx) mx = v;
          any |= masks[r][c];
        end
      end
      d[k*DW +: DW] = DW'((mode == 1) ? mx : sum / (w * w));
      m[k] = any;
    end
  endtask

  // Drive one tile (optionally aborted after row abort_after) and check every cycle.
  task automatic run_tile(input int w_code, input int mode, input int pat, input int max_gap,
                          input int abort_after, input bit garble, input string tag);
    int w, gap;
    bit have_out;
    logic [VW-1:0] ed;
    logic [DS-1:0] em;
    w = (w_code == 2 || w_code == 4) ? w_code : 1;
    for (int r = 0; r < TR; r++) begin
      for (int i = 0; i < DS; i++) begin
        rows[r][i*DW +: DW] = (pat == 1) ? DW'($urandom) : DW'(16 * r + i);
      end
      masks[r] = (pat == 1) ? DS'($urandom) : ((pat == 2) ? 16'hFFFD : 16'hFFFF);
    end
    strobes  = 0;
    dones    = 0;
    have_out = 1'b0;
    ed       = '0;
    em       = '0;
    enable_pool = 1'b1;
    for (int r = 0; r < TR; r++) begin
      if (r == 0 || !garble) begin
        pool_mode        = mode[0];
        pool_window_size = MBP'(w_code);
      end else begin
        pool_mode        = 1'($urandom);
        pool_window_size = MBP'($urandom);
      end
      inp_data          = rows[r];
      validity_mask     = masks[r];
      in_data_available = 1'b1;
      tick();
      if (out_data_available) strobes++;
      if (done_pool) dones++;
      if ((r % w) == w - 1) begin
        model_window(w, mode, r / w, ed, em);
        have_out = 1'b1;
        check_bit({tag, " strobe"}, out_data_available, 1'b1);
        check_vec({tag, " data"}, out_data, ed);
        check_vec({tag, " vmask"}, VW'(out_validity_mask), VW'(em));
        if (r / w == 0) begin
          first_data = out_data;
          first_mask = out_validity_mask;
        end
      end else begin
        check_bit({tag, " no_strobe"}, out_data_available, 1'b0);
      end
      check_bit({tag, " done"}, done_pool, (r == TR - 1));
      if (r == abort_after) begin
        enable_pool       = 1'b0;
        in_data_available = 1'b0;
        repeat (3) begin
          tick();
          check_bit({tag, " abort_no_strobe"}, out_data_available, 1'b0);
          check_bit({tag, " abort_no_done"}, done_pool, 1'b0);
        end
        return;
      end
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      in_data_available = 1'b0;
      for (int g = 0; g < gap; g++) begin
        inp_data = {4{$urandom}};
        if (garble) begin
          pool_mode        = 1'($urandom);
          pool_window_size = MBP'($urandom);
        end
        tick();
        if (out_data_available) strobes++;
        if (done_pool) dones++;
        check_bit({tag, " gap_no_strobe"}, out_data_available, 1'b0);
        check_bit({tag, " gap_no_done"}, done_pool, 1'b0);
        if (have_out) check_vec({tag, " gap_hold"}, out_data, ed);
      end
    end
    in_data_available = 1'b0;
    check_int({tag, " strobe_count"}, strobes, TR / w);
    check_int({tag, " done_count"}, dones, 1);
  endtask

  initial begin
    reset             = 1'b0;
    enable_pool       = 1'b0;
    pool_mode         = 1'b0;
    pool_window_size  = MBP'(1);
    in_data_available = 1'b0;
    inp_data          = '0;
    validity_mask     = '0;
    first_data        = '0;
    first_mask        = '0;

    // Reset values.
    repeat (2) tick();
    check_vec("reset out_data", out_data, '0);
    check_vec("reset vmask", VW'(out_validity_mask), '0);
    check_bit("reset dav", out_data_available, 1'b0);
    check_bit("reset done", done_pool, 1'b0);
    reset = 1'b1;
    tick();

    // Bypass: registered pass-through, strobe follows in_data_available.
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < DS; i++) begin
        inp_data[i*DW +: DW] = (n == 0) ? DW'(i + 1) : DW'($urandom);
      end
      validity_mask     = DS'($urandom);
      saved_data        = inp_data;
      saved_mask        = validity_mask;
      in_data_available = 1'b1;
      tick();
      check_vec("bypass data", out_data, saved_data);
      check_vec("bypass vmask", VW'(out_validity_mask), VW'(saved_mask));
      check_bit("bypass dav", out_data_available, 1'b1);
      check_bit("bypass done", done_pool, 1'b0);
    end
    in_data_available = 1'b0;
    tick();
    check_bit("bypass idle dav", out_data_available, 1'b0);

    // Directed tiles with known first-output values.
    run_tile(2, 0, 0, 0, -1, 1'b0, "avg2");
    check_int("avg2 lane0", int'(first_data[0 +: DW]), 8);
    check_int("avg2 lane7", int'(first_data[7*DW +: DW]), 22);
    check_vec("avg2 upper zero", VW'(first_data[VW-1:VW/2]), '0);
    check_vec("avg2 vmask", VW'(first_mask), VW'(16'h00FF));

    run_tile(2, 1, 0, 0, -1, 1'b0, "max2");
    check_int("max2 lane0", int'(first_data[0 +: DW]), 17);
    check_int("max2 lane7", int'(first_data[7*DW +: DW]), 31);

    run_tile(4, 0, 0, 0, -1, 1'b0, "avg4");
    check_int("avg4 lane0", int'(first_data[0 +: DW]), 25);
    check_int("avg4 lane3", int'(first_data[3*DW +: DW]), 37);
    check_vec("avg4 vmask", VW'(first_mask), VW'(16'h000F));

    run_tile(2, 0, 2, 0, -1, 1'b0, "mask");
    check_int("mask lane0", int'(first_data[0 +: DW]), 4);
    check_bit("mask vbit0", first_mask[0], 1'b1);

    // Random data, gaps and mid-tile config changes that must be ignored.
    run_tile(2, 0, 1, 3, -1, 1'b1, "gaps_avg2");
    run_tile(4, 1, 1, 2, -1, 1'b1, "rnd_max4");
    run_tile(1, 0, 1, 1, -1, 1'b1, "rnd_w1");
    run_tile(3, 1, 1, 0, -1, 1'b0, "w3_as_w1");
    run_tile(4, 0, 1, 0, -1, 1'b0, "rnd_avg4");

    // Abort after row 5, then a clean tile.
    run_tile(2, 0, 1, 1, 5, 1'b0, "abort");
    run_tile(2, 0, 0, 0, -1, 1'b0, "post_abort");
    check_int("post_abort lane0", int'(first_data[0 +: DW]), 8);

    // enable_pool falling together with a row: that row is passed through.
    enable_pool      = 1'b1;
    pool_mode        = 1'b0;
    pool_window_size = MBP'(4);
    for (int r = 0; r < 2; r++) begin
      inp_data          = rows[r];
      validity_mask     = masks[r];
      in_data_available = 1'b1;
      tick();
      check_bit("simul pre no_strobe", out_data_available, 1'b0);
    end
    enable_pool   = 1'b0;
    inp_data      = {4{$urandom}};
    validity_mask = DS'($urandom);
    saved_data    = inp_data;
    saved_mask    = validity_mask;
    tick();
    check_bit("simul dav", out_data_available, 1'b1);
    check_vec("simul data", out_data, saved_data);
    check_vec("simul vmask", VW'(out_validity_mask), VW'(saved_mask));
    check_bit("simul done", done_pool, 1'b0);
    in_data_available = 1'b0;
    tick();
    run_tile(4, 1, 1, 0, -1, 1'b0, "post_simul");

    // Asynchronous reset in the middle of a window.
    enable_pool      = 1'b1;
    pool_mode        = 1'b0;
    pool_window_size = MBP'(2);
    for (int r = 0; r < 3; r++) begin
      inp_data          = rows[r];
      validity_mask     = masks[r];
      in_data_available = 1'b1;
      tick();
    end
    reset = 1'b0;
    #1;
    check_vec("async_rst data", out_data, '0);
    check_vec("async_rst vmask", VW'(out_validity_mask), '0);
    check_bit("async_rst dav", out_data_available, 1'b0);
    check_bit("async_rst done", done_pool, 1'b0);
    in_data_available = 1'b0;
    tick();
    reset = 1'b1;
    run_tile(2, 0, 0, 0, -1, 1'b0, "post_reset");
    check_int("post_reset lane0", int'(first_data[0 +: DW]), 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
